// File: rtl/ro_pair_compare_pkg.sv
// Shared types and constants for the RO PUF pair-compare measurement core.
package ro_puf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2,
      DONE   = 2'd3
   } ro_state_t;

   localparam int N_RO_DEF       = 16;
   localparam int CNT_W_DEF      = 16;
   localparam int WIN_W_DEF      = 16;
   localparam int SETTLE_CYC_DEF = 4;

   // Flops between the asynchronous RO and the first clk-domain use.
   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ro_pair_compare_if.sv
// Challenge/response bus of ro_pair_compare; ro_en_o exists only when RO_GATE_EN is defined.
// Handshake: start_i is a request taken only while busy_o is low; done_o is a
// one-cycle valid for resp_o/cnt_a_o/cnt_b_o/err_o, with no backpressure.
interface ro_pair_compare_if
   import ro_puf_pkg::*;
#(
   parameter int N_RO  = N_RO_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
);
   localparam int SEL_W = $clog2(N_RO);

   logic [N_RO-1:0]  ro_i;
   logic             start_i;
   logic [SEL_W-1:0] sel_a_i;
   logic [SEL_W-1:0] sel_b_i;
   logic [WIN_W-1:0] window_i;
   logic             busy_o;
   logic             done_o;
   logic             resp_o;
   logic [CNT_W-1:0] cnt_a_o;
   logic [CNT_W-1:0] cnt_b_o;
   logic             err_o;
   ro_state_t        state_dbg;
`ifdef RO_GATE_EN
   logic [N_RO-1:0]  ro_en_o;
`endif

   modport master (
      output ro_i, start_i, sel_a_i, sel_b_i, window_i,
      input  busy_o, done_o, resp_o, cnt_a_o, cnt_b_o, err_o, state_dbg
`ifdef RO_GATE_EN
      , input ro_en_o
`endif
   );

   modport slave (
      input  ro_i, start_i, sel_a_i, sel_b_i, window_i,
      output busy_o, done_o, resp_o, cnt_a_o, cnt_b_o, err_o, state_dbg
`ifdef RO_GATE_EN
      , output ro_en_o
`endif
   );

endinterface

// File: rtl/ro_pair_compare_edge_counter.sv
// Synchroniser, rising-edge detector and saturating edge counter for one selected RO.
module ro_edge_counter
   import ro_puf_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro,
   input  logic             clr,
   input  logic             cnt_en,
   output logic [CNT_W-1:0] cnt_next
);

   // sh[0..SYNC_STAGES-1] form the synchroniser; sh[SYNC_STAGES] is the edge-detect history.
   logic [SYNC_STAGES:0] sh;
   logic [CNT_W-1:0]     cnt;
   logic                 rise;

   assign rise = sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];

   always_comb begin
      cnt_next = cnt;
      if (clr) begin
         cnt_next = '0;
      end else if (cnt_en && rise && (cnt != '1)) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh  <= '0;
         cnt <= '0;
      end else begin
         sh  <= {sh[SYNC_STAGES-1:0], ro};
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/ro_pair_compare.sv
// RO PUF measurement core: counts edges of two selected ROs over a window and compares them.
// Optional RO_GATE_EN adds ro_en_o, enabling only the selected pair during SETTLE/COUNT.
module ro_pair_compare
   import ro_puf_pkg::*;
#(
   parameter int N_RO       = N_RO_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int WIN_W      = WIN_W_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input logic              clk_i,
   input logic              rst_i,
   ro_pair_compare_if.slave bus
);

   localparam int SEL_W = $clog2(N_RO);
   localparam int N_PAD = 1 << SEL_W;
   localparam int ST_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SEL_W:0]  N_RO_L      = (SEL_W + 1)'(N_RO);
   localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYC - 1);

   ro_state_t        state_q, state_d;
   logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [WIN_W-1:0] win_q, win_d, win_cnt_q, win_cnt_d;
   logic [ST_W-1:0]  set_cnt_q, set_cnt_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic             resp_q, resp_d, err_q, err_d;
   logic             cnt_clr, cnt_en, chal_bad;
   logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
   logic [N_PAD-1:0] ro_pad;
   logic             ro_a, ro_b;

   // Out-of-range selectors land on padded zeros, so the mux never indexes past ro_i.
   always_comb begin
      ro_pad            = '0;
      ro_pad[N_RO-1:0]  = bus.ro_i;
   end

   assign ro_a = ro_pad[sel_a_q];
   assign ro_b = ro_pad[sel_b_q];

   always_comb begin
      chal_bad = (bus.sel_a_i == bus.sel_b_i)
              || ({1'b0, bus.sel_a_i} >= N_RO_L)
              || ({1'b0, bus.sel_b_i} >= N_RO_L)
              || (bus.window_i == '0);
   end

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk      (clk_i),
      .rst      (rst_i),
      .ro       (ro_a),
      .clr      (cnt_clr),
      .cnt_en   (cnt_en),
      .cnt_next (cnt_a_nxt)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk      (clk_i),
      .rst      (rst_i),
      .ro       (ro_b),
      .clr      (cnt_clr),
      .cnt_en   (cnt_en),
      .cnt_next (cnt_b_nxt)
   );

   always_comb begin
      state_d   = state_q;
      sel_a_d   = sel_a_q;
      sel_b_d   = sel_b_q;
      win_d     = win_q;
      set_cnt_d = set_cnt_q;
      win_cnt_d = win_cnt_q;
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;
      resp_d    = resp_q;
      err_d     = err_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (bus.start_i) begin
               sel_a_d = bus.sel_a_i;
               sel_b_d = bus.sel_b_i;
               win_d   = bus.window_i;
               if (chal_bad) begin
                  state_d = DONE;
                  cnt_a_d = '0;
                  cnt_b_d = '0;
                  resp_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  state_d   = SETTLE;
                  set_cnt_d = '0;
               end
            end
         end
         SETTLE: begin
            // Synchronisers keep running here so stale samples of the old pair flush out.
            cnt_clr = 1'b1;
            if (set_cnt_q == SETTLE_LAST) begin
               state_d   = COUNT;
               win_cnt_d = '0;
            end else begin
               set_cnt_d = set_cnt_q + ST_W'(1);
            end
         end
         COUNT: begin
            cnt_en = 1'b1;
            if (win_cnt_q == win_q - WIN_W'(1)) begin
               // Capture next-values so the final window cycle's edge is included.
               state_d = DONE;
               cnt_a_d = cnt_a_nxt;
               cnt_b_d = cnt_b_nxt;
               resp_d  = (cnt_a_nxt > cnt_b_nxt);
               err_d   = 1'b0;
            end else begin
               win_cnt_d = win_cnt_q + WIN_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         sel_a_q   <= '0;
         sel_b_q   <= '0;
         win_q     <= '0;
         set_cnt_q <= '0;
         win_cnt_q <= '0;
         cnt_a_q   <= '0;
         cnt_b_q   <= '0;
         resp_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_a_q   <= sel_a_d;
         sel_b_q   <= sel_b_d;
         win_q     <= win_d;
         set_cnt_q <= set_cnt_d;
         win_cnt_q <= win_cnt_d;
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
         resp_q    <= resp_d;
         err_q     <= err_d;
      end
   end

   assign bus.busy_o    = (state_q != IDLE);
   assign bus.done_o    = (state_q == DONE);
   assign bus.resp_o    = resp_q;
   assign bus.cnt_a_o   = cnt_a_q;
   assign bus.cnt_b_o   = cnt_b_q;
   assign bus.err_o     = err_q;
   assign bus.state_dbg = state_q;

`ifdef RO_GATE_EN
   logic [N_RO-1:0]  ro_en_q;
   logic [N_PAD-1:0] en_pad;

   // Derived from next-state so the pair is enabled on the very cycle SETTLE is entered.
   always_comb begin
      en_pad = '0;
      if ((state_d == SETTLE) || (state_d == COUNT)) begin
         en_pad[sel_a_d] = 1'b1;
         en_pad[sel_b_d] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ro_en_q <= '0;
      end else begin
         ro_en_q <= en_pad[N_RO-1:0];
      end
   end

   assign bus.ro_en_o = ro_en_q;
`endif

endmodule

// File: tb/tb_ro_pair_compare.sv
// Self-checking bench for ro_pair_compare: behavioural ROs, directed and random challenges.
module tb_ro_pair_compare;
   import ro_puf_pkg::*;

   localparam int SETTLE = 4;
   // Period of each bench RO in clk cycles (RO3 = 10, RO7 = 8).
   localparam int PER [16] = '{4, 6, 12, 10, 14, 16, 18, 8, 20, 22, 24, 26, 28, 30, 32, 34};

   logic clk;
   logic rst_i;
   int   cyc = 0;
   int   done_n1 = 0;
   int   done_n2 = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   ro_pair_compare_if #(.N_RO(16), .CNT_W(16), .WIN_W(16)) bif ();
   ro_pair_compare_if #(.N_RO(12), .CNT_W(4),  .WIN_W(16)) sif ();

   ro_pair_compare #(.N_RO(16), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bif)
   );

   ro_pair_compare #(.N_RO(12), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut_s (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (sif)
   );

   // ---------------- clock / reset / ROs ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bif.done_o) done_n1 <= done_n1 + 1;
      if (sif.done_o) done_n2 <= done_n2 + 1;
   end

   // RO toggles sit 2 time units after a negedge, well clear of both clock edges.
   logic ro_bit [16];
   for (genvar k = 0; k < 16; k++) begin : g_ro
      initial begin
         ro_bit[k] = 1'b0;
         #2;
         forever #(PER[k] * 5) ro_bit[k] = ~ro_bit[k];
      end
      assign bif.ro_i[k] = ro_bit[k];
   end

   logic ro4;
   initial begin
      ro4 = 1'b0;
      #2;
      forever #20 ro4 = ~ro4;
   end
   assign sif.ro_i = {12{ro4}};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
      n_tests++;
      assert ((obs >= lo) && (obs <= hi)) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic meas1(input int a, input int b, input int w, input bit poke,
                        output int lat, output int ca, output int cb,
                        output logic r, output logic e);
      int t0;
      bit legal;
      logic [15:0] mask;
      legal = (a != b) && (w != 0);
      mask  = legal ? ((16'd1 << a) | (16'd1 << b)) : 16'd0;
      @(negedge clk);
      bif.sel_a_i  = 4'(a);
      bif.sel_b_i  = 4'(b);
      bif.window_i = 16'(w);
      bif.start_i  = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bif.start_i = 1'b0;
      check("busy_after_start", bif.busy_o, 1);
`ifdef RO_GATE_EN
      check("ro_en_settle", bif.ro_en_o, mask);
`endif
      lat = -1;
      ca = 0;
      cb = 0;
      r = 1'b0;
      e = 1'b0;
      for (int i = 0; i < w + 60; i++) begin
         if (bif.done_o) begin
            lat = cyc - t0;
            ca  = bif.cnt_a_o;
            cb  = bif.cnt_b_o;
            r   = bif.resp_o;
            e   = bif.err_o;
            break;
         end
         if (i == 5) begin
            bif.sel_a_i  = 4'($urandom);
            bif.sel_b_i  = 4'($urandom);
            bif.window_i = 16'($urandom_range(1, 5));
         end
         if (poke && i == 10) begin
            bif.sel_a_i = 4'd5;
            bif.sel_b_i = 4'd5;
            bif.start_i = 1'b1;
         end
         if (poke && i == 12) bif.start_i = 1'b0;
`ifdef RO_GATE_EN
         if (i == w / 2) check("ro_en_count", bif.ro_en_o, mask);
`endif
         @(negedge clk);
      end
      if (lat >= 0) begin
`ifdef RO_GATE_EN
         check("ro_en_done", bif.ro_en_o, 0);
`endif
         @(negedge clk);
         check("done_one_cycle", bif.done_o, 0);
         check("cnt_a_held", bif.cnt_a_o, ca);
`ifdef RO_GATE_EN
         check("ro_en_idle", bif.ro_en_o, 0);
`endif
      end
   endtask

   task automatic meas2(input int a, input int b, input int w,
                        output int lat, output int ca, output int cb,
                        output logic r, output logic e);
      int t0;
      @(negedge clk);
      sif.sel_a_i  = 4'(a);
      sif.sel_b_i  = 4'(b);
      sif.window_i = 16'(w);
      sif.start_i  = 1'b1;
      t0 = cyc;
      @(negedge clk);
      sif.start_i = 1'b0;
      lat = -1;
      ca = 0;
      cb = 0;
      r = 1'b0;
      e = 1'b0;
      for (int i = 0; i < w + 60; i++) begin
         if (sif.done_o) begin
            lat = cyc - t0;
            ca  = sif.cnt_a_o;
            cb  = sif.cnt_b_o;
            r   = sif.resp_o;
            e   = sif.err_o;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Reference model: a free-running RO of period p gives about w/p rising edges in w cycles.
   task automatic check_legal(input string tag, input int a, input int b, input int w,
                              input int lat, input int ca, input int cb,
                              input logic r, input logic e);
      int ea, eb;
      ea = w / PER[a];
      eb = w / PER[b];
      check({tag, "_lat"}, lat, 1 + SETTLE + w);
      check({tag, "_err"}, e, 0);
      check_rng({tag, "_cnt_a"}, ca, ea - 1, ea + 1);
      check_rng({tag, "_cnt_b"}, cb, eb - 1, eb + 1);
      if ((ea - eb >= 3) || (eb - ea >= 3)) check({tag, "_resp"}, r, (ea > eb));
      else check({tag, "_resp_tie_rule"}, r, (ca > cb));
   endtask

   task automatic check_err(input string tag, input int lat, input int ca, input int cb,
                            input logic r, input logic e);
      check({tag, "_lat"}, lat, 1);
      check({tag, "_err"}, e, 1);
      check({tag, "_cnt_a"}, ca, 0);
      check({tag, "_cnt_b"}, cb, 0);
      check({tag, "_resp"}, r, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat, ca, cb, a, b, w, d0;
      logic r, e;

      rst_i        = 1'b1;
      bif.start_i  = 1'b0;
      bif.sel_a_i  = '0;
      bif.sel_b_i  = '0;
      bif.window_i = '0;
      sif.start_i  = 1'b0;
      sif.sel_a_i  = '0;
      sif.sel_b_i  = '0;
      sif.window_i = '0;
      #1;
      check("rst_busy", bif.busy_o, 0);
      check("rst_done", bif.done_o, 0);
      check("rst_resp", bif.resp_o, 0);
      check("rst_err", bif.err_o, 0);
      check("rst_cnt_a", bif.cnt_a_o, 0);
      check("rst_cnt_b", bif.cnt_b_o, 0);
      check("rst_state", bif.state_dbg, IDLE);
      check("rst_s_cnt_a", sif.cnt_a_o, 0);
`ifdef RO_GATE_EN
      check("rst_ro_en", bif.ro_en_o, 0);
`endif
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      repeat (4) @(negedge clk);

      meas1(3, 7, 800, 1'b0, lat, ca, cb, r, e);
      check_legal("ab_3_7", 3, 7, 800, lat, ca, cb, r, e);
      check("ab_3_7_resp_exact", r, 0);

      d0 = done_n1;
      meas1(7, 3, 800, 1'b1, lat, ca, cb, r, e);
      check_legal("ab_7_3", 7, 3, 800, lat, ca, cb, r, e);
      check("ab_7_3_resp_exact", r, 1);
      repeat (20) @(negedge clk);
      check("start_while_busy_one_done", done_n1 - d0, 1);

      meas1(5, 5, 300, 1'b0, lat, ca, cb, r, e);
      check_err("err_same_sel", lat, ca, cb, r, e);

      meas1(3, 7, 0, 1'b0, lat, ca, cb, r, e);
      check_err("err_win0", lat, ca, cb, r, e);

      meas1(2, 9, 300, 1'b0, lat, ca, cb, r, e);
      check_legal("ab_2_9", 2, 9, 300, lat, ca, cb, r, e);

      for (int t = 0; t < 6; t++) begin
         a = $urandom_range(0, 15);
         do b = $urandom_range(0, 15); while (b == a);
         w = $urandom_range(300, 1000);
         meas1(a, b, w, 1'b0, lat, ca, cb, r, e);
         check_legal($sformatf("rand%0d", t), a, b, w, lat, ca, cb, r, e);
      end

      // Reset during COUNT: outputs clear at once and no done follows.
      @(negedge clk);
      bif.sel_a_i  = 4'd3;
      bif.sel_b_i  = 4'd7;
      bif.window_i = 16'd800;
      bif.start_i  = 1'b1;
      @(negedge clk);
      bif.start_i = 1'b0;
      repeat (200) @(negedge clk);
      check("midrst_busy_before", bif.busy_o, 1);
      rst_i = 1'b1;
      #1;
      check("midrst_busy", bif.busy_o, 0);
      check("midrst_done", bif.done_o, 0);
      check("midrst_cnt_a", bif.cnt_a_o, 0);
      check("midrst_cnt_b", bif.cnt_b_o, 0);
      check("midrst_state", bif.state_dbg, IDLE);
      d0 = done_n1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      repeat (900) @(negedge clk);
      check("midrst_no_done", done_n1 - d0, 0);
      meas1(3, 7, 400, 1'b0, lat, ca, cb, r, e);
      check_legal("after_rst", 3, 7, 400, lat, ca, cb, r, e);

      // Narrow-counter / 12-RO instance: saturation and out-of-range selectors.
      meas2(0, 1, 40, lat, ca, cb, r, e);
      check("s_small_lat", lat, 1 + SETTLE + 40);
      check_rng("s_small_cnt_a", ca, 9, 11);
      meas2(0, 1, 200, lat, ca, cb, r, e);
      check("s_sat_lat", lat, 1 + SETTLE + 200);
      check("s_sat_cnt_a", ca, 15);
      check("s_sat_cnt_b", cb, 15);
      check("s_sat_resp_tie", r, 0);
      check("s_sat_err", e, 0);
      meas2(12, 1, 100, lat, ca, cb, r, e);
      check_err("s_err_sel_a_range", lat, ca, cb, r, e);
      meas2(2, 15, 100, lat, ca, cb, r, e);
      check_err("s_err_sel_b_range", lat, ca, cb, r, e);
      repeat (5) @(negedge clk);
      check("s_done_total", done_n2, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
